// File: rtl/huff_pkg.sv
// Shared constants and types for the serial Huffman decoder.
package huff_pkg;

  localparam int unsigned SYM_NUM = 10;
  localparam int unsigned MAX_LEN = 9;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SYM_W   = 4;
  localparam int unsigned CNT_W   = 9;

  localparam logic [SYM_W-1:0] SYM_END   = 4'hF;
  localparam logic [CNT_W-1:0] TOTAL_MAX = 9'd256;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  typedef struct packed {
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
  } tbl_entry_t;

endpackage

// File: rtl/huff_match.sv
// Combinational priority matcher: lowest table index whose full codeword equals
// the bits accumulated so far wins.
module huff_match
  import huff_pkg::*;
(
  input  logic [MAX_LEN-1:0]       acc_next,
  input  logic [LEN_W-1:0]         cnt_next,
  input  tbl_entry_t [SYM_NUM-1:0] tbl,
  output logic                     hit,
  output logic [SYM_W-1:0]         hit_sym
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    hit     = 1'b0;
    hit_sym = '0;
    mask    = '0;
    for (int i = 0; i < int'(SYM_NUM); i++) begin
      // A 9-bit length wraps the shifted one to zero, giving an all-ones mask.
      mask = (MAX_LEN'(1) << tbl[i].len) - MAX_LEN'(1);
      if (!hit && (tbl[i].len != '0) && (tbl[i].len == cnt_next) &&
          ((acc_next & mask) == (tbl[i].code & mask))) begin
        hit     = 1'b1;
        hit_sym = SYM_W'(i);
      end
    end
  end

endmodule

// File: rtl/huff_decode.sv
// Serial MSB-first Huffman decoder: programmable 10-entry code table, emits one
// digit per codeword and a 4'hF end marker once the requested count is reached.
module huff_decode #(
  parameter int unsigned SYM_NUM = 10,
  parameter int unsigned MAX_LEN = 9
) (
  input  logic               Clk_in,
  input  logic               nRst,
  input  logic               Tbl_we,
  input  logic [3:0]         Tbl_sym,
  input  logic [MAX_LEN-1:0] Tbl_code,
  input  logic [3:0]         Tbl_len,
  input  logic [8:0]         Sym_total,
  input  logic               Start,
  input  logic               Bit_in,
  input  logic               Bit_valid,
  output logic               Ready,
  output logic [3:0]         Data_out,
  output logic               Data_valid,
  output logic               Done,
  output logic               Err
);

  import huff_pkg::*;

  state_t                   state_q, state_d;
  tbl_entry_t [SYM_NUM-1:0] tbl_q;
  logic [MAX_LEN-2:0]       acc_q, acc_d;
  logic [MAX_LEN-1:0]       acc_next;
  logic [LEN_W-1:0]         cnt_q, cnt_d, cnt_next;
  logic [CNT_W-1:0]         sym_cnt_q, sym_cnt_d, sym_cnt_inc;
  logic [CNT_W-1:0]         total_q, total_d;
  logic                     fin_q, fin_d;
  logic [SYM_W-1:0]         data_d;
  logic                     valid_d, ready_d, done_d, err_d;
  logic                     hit;
  logic [SYM_W-1:0]         hit_sym;
  logic                     consume_c, tbl_we_c;

  assign acc_next    = {acc_q, Bit_in};
  assign cnt_next    = cnt_q + LEN_W'(1);
  assign sym_cnt_inc = sym_cnt_q + CNT_W'(1);
  assign consume_c   = (state_q == S_RUN) && Bit_valid && !Start;
  assign tbl_we_c    = Tbl_we && (state_q != S_RUN) && (Tbl_sym < SYM_W'(SYM_NUM));

  huff_match u_match (
    .acc_next (acc_next),
    .cnt_next (cnt_next),
    .tbl      (tbl_q),
    .hit      (hit),
    .hit_sym  (hit_sym)
  );

  // Code table; frozen while a decode is running.
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      tbl_q <= '0;
    end else if (tbl_we_c) begin
      tbl_q[Tbl_sym] <= '{code: Tbl_code, len: Tbl_len};
    end
  end

  // Next state; fin flags that the end marker is owed on the first DONE cycle.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sym_cnt_d = sym_cnt_q;
    total_d   = total_q;
    fin_d     = 1'b0;
    data_d    = '0;
    valid_d   = 1'b0;

    if (Start) begin
      total_d   = (Sym_total > TOTAL_MAX) ? TOTAL_MAX : Sym_total;
      sym_cnt_d = '0;
      acc_d     = '0;
      cnt_d     = '0;
      if (Sym_total == '0) begin
        state_d = S_DONE;
        data_d  = SYM_END;
        valid_d = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (consume_c) begin
            if (hit) begin
              acc_d     = '0;
              cnt_d     = '0;
              sym_cnt_d = sym_cnt_inc;
              data_d    = hit_sym;
              valid_d   = 1'b1;
              if (sym_cnt_inc == total_q) begin
                state_d = S_DONE;
                fin_d   = 1'b1;
              end
            end else if (cnt_next == LEN_W'(MAX_LEN)) begin
              state_d = S_ERR;
            end else begin
              acc_d = acc_next[MAX_LEN-2:0];
              cnt_d = cnt_next;
            end
          end
        end
        S_DONE: begin
          if (fin_q) begin
            data_d  = SYM_END;
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    ready_d = (state_d == S_RUN);
    err_d   = (state_d == S_ERR);
    done_d  = (state_q == S_DONE) && !fin_q && !Start;
  end

  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      sym_cnt_q  <= '0;
      total_q    <= '0;
      fin_q      <= 1'b0;
      Data_out   <= '0;
      Data_valid <= 1'b0;
      Ready      <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      total_q    <= total_d;
      fin_q      <= fin_d;
      Data_valid <= valid_d;
      if (valid_d) Data_out <= data_d;
      Ready      <= ready_d;
      Done       <= done_d;
      Err        <= err_d;
    end
  end

endmodule
